// File: rtl/sram_stream_reader_pkg.sv
// Shared types and default sizes for the SRAM stream reader and its return FIFO.
package sram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int DEF_ADDR_W     = 20;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_LEN_W      = 21;
    localparam int DEF_FIFO_DEPTH = 16;

    // Counts must represent 0..depth inclusive, hence one extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_FIFO_DEPTH);

endpackage

// File: rtl/sram_stream_fifo.sv
// Synchronous show-ahead FIFO: o_data always presents the head word while not empty.
module sram_stream_fifo
    import sram_stream_reader_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = cnt_width(FIFO_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == DEPTH_V);
    assign o_count = r_count;

endmodule

// File: rtl/sram_stream_reader.sv
// Avalon-MM read master streaming sequential SRAM words through a credit-limited FIFO.
// Optional continuous looping over the buffer is enabled by SRAM_STREAM_READER_LOOP_EN.
module sram_stream_reader
    import sram_stream_reader_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
`ifdef SRAM_STREAM_READER_LOOP_EN
    input  logic              cfg_loop,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address,
    output logic [1:0]        byteenable,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    input  logic              readdatavalid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output state_e            o_dbg_state
);

    localparam int CNT_W = cnt_width(FIFO_DEPTH);
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_address;
    logic [LEN_W-1:0]  r_remaining;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_push_left;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              r_read;
    logic              r_done;
    logic              w_loop;
    logic              w_start;
    logic              w_credit;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_empty;
    logic              w_fifo_full;

    assign w_start      = cfg_start && (r_state == IDLE);
    // Credit counts words already in the FIFO plus reads whose data is still in flight.
    assign w_credit     = ({1'b0, w_fifo_count} + {1'b0, r_outstanding}) < DEPTH_V;
    assign w_issue      = (r_state == RUN) && (r_remaining != '0) && w_credit;
    assign w_last_issue = w_issue && (r_remaining == LEN_W'(1));
    assign w_push       = readdatavalid && (r_outstanding != '0);
    assign w_pop        = !w_fifo_empty && out_ready;

`ifdef SRAM_STREAM_READER_LOOP_EN
    logic r_loop;

    // A fresh start without loop while busy only cancels looping after this pass.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_loop <= 1'b0;
        end else if (w_start) begin
            r_loop <= cfg_loop;
        end else if (cfg_start && !cfg_loop) begin
            r_loop <= 1'b0;
        end
    end

    assign w_loop = r_loop;
`else
    assign w_loop = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start && (cfg_len != '0)) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last_issue && !w_loop) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((r_outstanding == '0) || ((r_outstanding == CNT_W'(1)) && w_push)) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_base        <= '0;
            r_len         <= '0;
            r_remaining   <= '0;
            r_push_left   <= '0;
            r_outstanding <= '0;
            r_address     <= '0;
            r_read        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_read  <= w_issue;
            r_done  <= (w_start && (cfg_len == '0)) || (w_push && (r_push_left == LEN_W'(1)));

            if (w_start) begin
                r_addr      <= cfg_base;
                r_base      <= cfg_base;
                r_remaining <= cfg_len;
                r_len       <= cfg_len;
                r_push_left <= cfg_len;
            end else begin
                if (w_issue) begin
                    r_address <= r_addr;
                    if (w_last_issue && w_loop) begin
                        r_addr      <= r_base;
                        r_remaining <= r_len;
                    end else begin
                        r_addr      <= r_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                    end
                end
                // Pass boundaries follow the in-order return stream, not the issue side.
                if (w_push) begin
                    r_push_left <= (r_push_left == LEN_W'(1)) ? r_len : r_push_left - 1'b1;
                end
            end

            if (w_issue && !w_push) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (!w_issue && w_push) begin
                r_outstanding <= r_outstanding - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(w_push && w_fifo_full));
        end
    end

    sram_stream_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .i_clk     (clk),
        .i_reset_n (reset),
        .i_push    (w_push),
        .i_data    (readdata),
        .i_pop     (w_pop),
        .o_data    (out_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign address     = r_address;
    assign read        = r_read;
    assign byteenable  = 2'b11;
    assign write       = 1'b0;
    assign writedata   = '0;
    assign out_valid   = !w_fifo_empty;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: SRAM responder, stream monitor and per-scenario checks.
module tb_sram_stream_reader;
    import sram_stream_reader_pkg::*;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 21;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_start;
    logic [ADDR_W-1:0] cfg_base;
    logic [LEN_W-1:0]  cfg_len;
`ifdef SRAM_STREAM_READER_LOOP_EN
    logic              cfg_loop;
`endif
    logic              busy, done, read, write, readdatavalid, out_valid, out_ready;
    logic [ADDR_W-1:0] address;
    logic [1:0]        byteenable;
    logic [DATA_W-1:0] writedata, readdata, out_data;
    state_e            dbg_state;

    sram_stream_reader dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_base(cfg_base), .cfg_len(cfg_len),
`ifdef SRAM_STREAM_READER_LOOP_EN
        .cfg_loop(cfg_loop),
`endif
        .busy(busy), .done(done), .address(address), .byteenable(byteenable), .read(read),
        .write(write), .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [15:0] seed = 16'h1234;
    int ready_mode = 0;
    logic ready_level = 1'b1;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] obs_addr_q[$];
    logic [DATA_W-1:0] obs_data_q[$];
    int                obs_read_cyc_q[$];
    logic [1:0]        done_busy_q[$];
    int                done_cnt = 0;
    logic              last_busy = 1'b0;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return (a[15:0] * 16'h9E37) ^ {a[19:16], a[19:16], a[19:16], a[19:16]} ^ seed;
    endfunction

    // Reference model: a transfer is just len consecutive addresses modulo 2^ADDR_W.
    task automatic build_expect(input logic [ADDR_W-1:0] base, input int len);
        exp_addr_q.delete();
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            logic [ADDR_W-1:0] a;
            a = base + ADDR_W'(i);
            exp_addr_q.push_back(a);
            exp_q.push_back(mem_word(a));
        end
    endtask

    // ---------------- SRAM responder (fixed latency, shares reset) ----------------
    logic              pv [2];
    logic [ADDR_W-1:0] pa [2];
    initial begin
        pv[0] = 1'b0; pv[1] = 1'b0; pa[0] = '0; pa[1] = '0;
        readdatavalid = 1'b0;
        readdata = '0;
        forever begin
            @(posedge clk); #1;
            if (reset !== 1'b1) begin
                pv[0] = 1'b0; pv[1] = 1'b0;
                readdatavalid = 1'b0;
            end else begin
                readdatavalid = pv[1];
                readdata = mem_word(pa[1]);
                pv[1] = pv[0]; pa[1] = pa[0];
                pv[0] = read;  pa[0] = address;
            end
        end
    end

    // ---------------- consumer ready driver ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : ready_level;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (read === 1'b1) begin
                obs_addr_q.push_back(address);
                obs_read_cyc_q.push_back(cyc);
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) obs_data_q.push_back(out_data);
            if (done === 1'b1) begin
                done_cnt++;
                done_busy_q.push_back({last_busy, busy});
            end
            last_busy = busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_obs();
        obs_addr_q.delete();
        obs_data_q.delete();
        obs_read_cyc_q.delete();
        done_busy_q.delete();
        done_cnt = 0;
    endtask

    task automatic start_xfer(input logic [ADDR_W-1:0] base, input int len, input logic loop_en);
        cfg_base = base;
        cfg_len = LEN_W'(len);
`ifdef SRAM_STREAM_READER_LOOP_EN
        cfg_loop = loop_en;
`else
        if (loop_en) $display("note: loop requested on a one-shot build");
`endif
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (busy === 1'b0 && out_valid === 1'b0) begin
                ok = 1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s timeout: busy=%b out_valid=%b after %0d cycles, required idle", name, busy, out_valid, budget);
        end
        step(); step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        vectors += 8;
        if (busy !== 1'b0)       begin miscompares++; $display("FAIL rst_busy got %b exp 0", busy); end
        if (done !== 1'b0)       begin miscompares++; $display("FAIL rst_done got %b exp 0", done); end
        if (read !== 1'b0)       begin miscompares++; $display("FAIL rst_read got %b exp 0", read); end
        if (address !== '0)      begin miscompares++; $display("FAIL rst_address got %h exp 0", address); end
        if (out_valid !== 1'b0)  begin miscompares++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        if (byteenable !== 2'b11) begin miscompares++; $display("FAIL rst_byteenable got %b exp 11", byteenable); end
        if (write !== 1'b0 || writedata !== '0) begin miscompares++; $display("FAIL rst_write got %b/%h exp 0/0", write, writedata); end
        if (dbg_state !== IDLE)  begin miscompares++; $display("FAIL rst_state got %0d exp IDLE", dbg_state); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        clear_obs();
        ready_mode = 0; ready_level = 1'b1;
        build_expect(20'h00010, 4);
        start_xfer(20'h00010, 4, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_after_start got %b exp 1", busy); end
        wait_idle("basic", 200);
        vectors++;
        if (obs_addr_q.size() != 4) begin miscompares++; $display("FAIL basic_nreads got %0d exp 4", obs_addr_q.size()); end
        foreach (exp_addr_q[i]) if (i < obs_addr_q.size()) begin
            vectors++;
            if (obs_addr_q[i] !== exp_addr_q[i]) begin miscompares++; $display("FAIL basic_addr[%0d] got %h exp %h", i, obs_addr_q[i], exp_addr_q[i]); end
        end
        foreach (exp_q[i]) begin
            vectors++;
            if (i >= obs_data_q.size() || obs_data_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL basic_data[%0d] got %h exp %h", i, (i < obs_data_q.size()) ? obs_data_q[i] : 'x, exp_q[i]);
            end
        end
        vectors += 2;
        if (obs_read_cyc_q.size() == 4 && obs_read_cyc_q[3] - obs_read_cyc_q[0] != 3) begin
            miscompares++; $display("FAIL basic_back_to_back span got %0d exp 3", obs_read_cyc_q[3] - obs_read_cyc_q[0]);
        end
        if (done_cnt != 1 || done_busy_q.size() != 1 || done_busy_q[0] !== 2'b10) begin
            miscompares++; $display("FAIL basic_done pulses got %0d busy_prev_now %b exp 1 pulse 10", done_cnt, (done_busy_q.size() > 0) ? done_busy_q[0] : 2'bxx);
        end
    endtask

    task automatic test_backpressure();
        logic [ADDR_W-1:0] base;
        clear_obs();
        base = ADDR_W'($urandom);
        ready_mode = 0; ready_level = 1'b0;
        build_expect(base, 40);
        start_xfer(base, 40, 1'b0);
        repeat (30) step();
        vectors++;
        if (obs_addr_q.size() != 16) begin miscompares++; $display("FAIL bp_reads_at_30 got %0d exp 16", obs_addr_q.size()); end
        repeat (30) step();
        vectors += 2;
        if (obs_addr_q.size() != 16) begin miscompares++; $display("FAIL bp_reads_at_60 got %0d exp 16", obs_addr_q.size()); end
        if (out_valid !== 1'b1 || read !== 1'b0) begin miscompares++; $display("FAIL bp_stall out_valid=%b read=%b exp 1/0", out_valid, read); end
        ready_level = 1'b1;
        wait_idle("backpressure", 400);
        vectors += 2;
        if (obs_addr_q.size() != 40) begin miscompares++; $display("FAIL bp_nreads got %0d exp 40", obs_addr_q.size()); end
        if (obs_data_q.size() != 40) begin miscompares++; $display("FAIL bp_nwords got %0d exp 40", obs_data_q.size()); end
        foreach (exp_q[i]) if (i < obs_data_q.size() && i < obs_addr_q.size()) begin
            vectors++;
            if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL bp_word[%0d] got %h/%h exp %h/%h", i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_wrap();
        clear_obs();
        ready_mode = 0; ready_level = 1'b1;
        build_expect(20'hFFFFE, 4);
        start_xfer(20'hFFFFE, 4, 1'b0);
        wait_idle("wrap", 200);
        vectors++;
        if (obs_addr_q.size() != 4) begin miscompares++; $display("FAIL wrap_nreads got %0d exp 4", obs_addr_q.size()); end
        foreach (exp_addr_q[i]) if (i < obs_addr_q.size()) begin
            vectors++;
            if (obs_addr_q[i] !== exp_addr_q[i]) begin miscompares++; $display("FAIL wrap_addr[%0d] got %h exp %h", i, obs_addr_q[i], exp_addr_q[i]); end
        end
        foreach (exp_q[i]) begin
            vectors++;
            if (i >= obs_data_q.size() || obs_data_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL wrap_data[%0d] exp %h", i, exp_q[i]); end
        end
    endtask

    task automatic test_zero_len();
        clear_obs();
        start_xfer(20'h00123, 0, 1'b0);
        vectors += 2;
        if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done_next got %b exp 1", done); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy got %b exp 0", busy); end
        step();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL zero_after done=%b busy=%b exp 0/0", done, busy); end
        repeat (5) step();
        vectors++;
        if (obs_addr_q.size() != 0 || done_cnt != 1) begin
            miscompares++; $display("FAIL zero_quiet reads=%0d dones=%0d exp 0/1", obs_addr_q.size(), done_cnt);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            logic [ADDR_W-1:0] base;
            int len;
            clear_obs();
            seed = 16'($urandom);
            base = ADDR_W'($urandom);
            len = $urandom_range(1, 40);
            ready_mode = 1;
            build_expect(base, len);
            start_xfer(base, len, 1'b0);
            wait_idle("random", 600);
            vectors += 2;
            if (obs_data_q.size() != len) begin miscompares++; $display("FAIL rand%0d_nwords got %0d exp %0d", t, obs_data_q.size(), len); end
            if (done_cnt != 1) begin miscompares++; $display("FAIL rand%0d_done got %0d exp 1", t, done_cnt); end
            foreach (exp_q[i]) if (i < obs_data_q.size() && i < obs_addr_q.size()) begin
                vectors++;
                if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_q[i]) begin
                    miscompares++; $display("FAIL rand%0d_word[%0d] got %h/%h exp %h/%h", t, i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_q[i]);
                end
            end
        end
        ready_mode = 0; ready_level = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        int nreads, na, nd;
        bit hit;
        clear_obs();
        nreads = 0; hit = 0;
        start_xfer(20'h00300, 10, 1'b0);
        for (int i = 0; i < 50 && !hit; i++) begin
            step();
            if (read === 1'b1) nreads++;
            if (nreads == 3) begin reset = 1'b0; hit = 1; end
        end
        vectors++;
        if (!hit) begin miscompares++; $display("FAIL rstmid_third_read got %0d reads exp 3", nreads); end
        step();
        vectors++;
        if (read !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_cleared read=%b out_valid=%b busy=%b exp 0/0/0", read, out_valid, busy);
        end
        reset = 1'b1;
        na = obs_addr_q.size();
        nd = obs_data_q.size();
        repeat (30) step();
        vectors += 2;
        if (na != 3 || obs_addr_q.size() != na) begin miscompares++; $display("FAIL rstmid_reads got %0d then %0d exp 3 then 3", na, obs_addr_q.size()); end
        if (obs_data_q.size() != nd || done_cnt != 0) begin
            miscompares++; $display("FAIL rstmid_delivery words %0d->%0d dones %0d exp no change 0", nd, obs_data_q.size(), done_cnt);
        end
    endtask

    task automatic test_ignored_start();
        int nreads;
        clear_obs();
        nreads = 0;
        build_expect(20'h00200, 12);
        start_xfer(20'h00200, 12, 1'b0);
        for (int i = 0; i < 40 && nreads < 3; i++) begin
            step();
            if (read === 1'b1) nreads++;
        end
        start_xfer(20'h00500, 5, 1'b0);
        wait_idle("ignored_start", 300);
        vectors += 2;
        if (obs_addr_q.size() != 12) begin miscompares++; $display("FAIL ign_nreads got %0d exp 12", obs_addr_q.size()); end
        if (done_cnt != 1) begin miscompares++; $display("FAIL ign_done got %0d exp 1", done_cnt); end
        foreach (exp_q[i]) if (i < obs_data_q.size() && i < obs_addr_q.size()) begin
            vectors++;
            if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL ign_word[%0d] got %h/%h exp %h/%h", i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_q[i]);
            end
        end
    endtask

`ifdef SRAM_STREAM_READER_LOOP_EN
    task automatic test_loop();
        int n;
        clear_obs();
        start_xfer(20'h00020, 3, 1'b1);
        for (int i = 0; i < 100 && obs_addr_q.size() < 9; i++) step();
        start_xfer(20'h00700, 2, 1'b0);
        wait_idle("loop", 300);
        n = obs_addr_q.size();
        vectors += 3;
        if (n < 9 || n % 3 != 0) begin miscompares++; $display("FAIL loop_nreads got %0d exp multiple of 3 >= 9", n); end
        if (n > 0 && obs_read_cyc_q[n-1] - obs_read_cyc_q[0] != n - 1) begin
            miscompares++; $display("FAIL loop_gapless span got %0d exp %0d", obs_read_cyc_q[n-1] - obs_read_cyc_q[0], n - 1);
        end
        if (done_cnt != n / 3) begin miscompares++; $display("FAIL loop_done got %0d exp %0d", done_cnt, n / 3); end
        for (int i = 0; i < n; i++) begin
            logic [ADDR_W-1:0] a;
            a = 20'h00020 + ADDR_W'(i % 3);
            vectors++;
            if (obs_addr_q[i] !== a || i >= obs_data_q.size() || obs_data_q[i] !== mem_word(a)) begin
                miscompares++; $display("FAIL loop_word[%0d] addr got %h exp %h", i, obs_addr_q[i], a);
            end
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b0;
        cfg_start = 1'b0;
        cfg_base = '0;
        cfg_len = '0;
`ifdef SRAM_STREAM_READER_LOOP_EN
        cfg_loop = 1'b0;
`endif
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_random();
        test_reset_mid();
        test_ignored_start();
`ifdef SRAM_STREAM_READER_LOOP_EN
        test_loop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
